// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin / fixed-select stream multiplexer.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a flattened bus carrying nch channels of w bits each.
    function automatic int unsigned flat_w(input int unsigned nch, input int unsigned w);
        return nch * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward (wrapping), owns ptr.
// ptr follows whichever index the parent actually granted, so a fixed-select
// grant also moves the round-robin starting point.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 8,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              enable,
    input  logic              upd_en,
    input  logic [SEL_W-1:0]  upd_idx,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] ptr;

    // First requester after ptr wins; nothing is granted while disabled.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(ptr) + k) % NUM_CH;
            if (!found && req[SEL_W'(idx)]) begin
                found                = 1'b1;
                grant[SEL_W'(idx)]   = 1'b1;
                grant_idx            = SEL_W'(idx);
            end
        end
        if (!enable) begin
            grant     = '0;
            grant_idx = '0;
        end
    end

    // Pointer tracks the last granted channel; resets so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SEL_W'(NUM_CH - 1);
        end else if (upd_en) begin
            ptr <= upd_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select or round-robin
// arbitration and a single full-throughput output register.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 8,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [flat_w(NUM_CH, WIDTH)-1:0]      in_data,
    input  logic [NUM_CH-1:0]                     in_valid,
    output logic [NUM_CH-1:0]                     in_ready,
    input  logic                                  mode,
    input  logic [SEL_W-1:0]                      sel,
    output logic [WIDTH-1:0]                      out_data,
    output logic [SEL_W-1:0]                      out_ch,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    logic              load_en_c;
    logic              rr_en_c;
    logic [NUM_CH-1:0] fix_grant_c;
    logic [NUM_CH-1:0] rr_grant_c;
    logic [SEL_W-1:0]  rr_idx_c;
    logic [NUM_CH-1:0] grant_c;
    logic [SEL_W-1:0]  grant_idx_c;
    logic              any_grant_c;
    logic [WIDTH-1:0]  mux_data_c;

    // Output register can take a word when empty or being drained this cycle.
    assign load_en_c = !out_valid || out_ready;
    assign rr_en_c   = load_en_c && (mode == MODE_RR) && !rst;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .enable    (rr_en_c),
        .upd_en    (any_grant_c),
        .upd_idx   (grant_idx_c),
        .grant     (rr_grant_c),
        .grant_idx (rr_idx_c)
    );

    // Fixed decode looks only at the selected channel; out-of-range sel matches nothing.
    always_comb begin
        fix_grant_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_grant_c[i] = in_valid[i] && load_en_c && !rst && (mode == MODE_FIXED);
            end
        end
    end

    // Pick the active mode's grant.
    always_comb begin
        grant_c     = fix_grant_c;
        grant_idx_c = sel;
        if (mode == MODE_RR) begin
            grant_c     = rr_grant_c;
            grant_idx_c = rr_idx_c;
        end
    end

    assign any_grant_c = |grant_c;
    assign in_ready    = grant_c;

    // AND-OR data select over the one-hot grant.
    always_comb begin
        mux_data_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mux_data_c = mux_data_c | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_c[i]}});
        end
    end

    // Output register: load on grant, drain to empty when consumed without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (any_grant_c) begin
            out_valid <= 1'b1;
            out_data  <= mux_data_c;
            out_ch    <= grant_idx_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: 8x32 vector table plus reset, sweep and
// small-configuration sequences.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8 channels x 32 bits
    logic [255:0] in_data;
    logic [7:0]   in_valid, in_ready;
    logic         mode, out_valid, out_ready;
    logic [2:0]   sel, out_ch;
    logic [31:0]  out_data;

    // 3 channels x 16 bits
    logic [47:0]  d3_in;
    logic [2:0]   v3, r3;
    logic         m3, ov3, or3;
    logic [1:0]   s3, ch3;
    logic [15:0]  od3;

    // 4 channels x 64 bits
    logic [255:0] d4_in;
    logic [3:0]   v4, r4;
    logic         m4, ov4, or4;
    logic [1:0]   s4, ch4;
    logic [63:0]  od4;

    stream_mux_rr #(.WIDTH(32), .NUM_CH(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready));

    stream_mux_rr #(.WIDTH(16), .NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3_in), .in_valid(v3), .in_ready(r3),
        .mode(m3), .sel(s3), .out_data(od3), .out_ch(ch3),
        .out_valid(ov3), .out_ready(or3));

    stream_mux_rr #(.WIDTH(64), .NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(d4_in), .in_valid(v4), .in_ready(r4),
        .mode(m4), .sel(s4), .out_data(od4), .out_ch(ch4),
        .out_valid(ov4), .out_ready(or4));

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] valid;
        logic       ordy;
        logic [7:0] exp_ready;
        logic       exp_valid;
        logic [2:0] exp_ch;
    } vec_t;

    vec_t vecs[20];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one table row: check in_ready before the edge, outputs after it.
    task automatic run_vec(input vec_t v, input int n);
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.valid;
        out_ready = v.ordy;
        #1;
        chk($sformatf("vec%0d in_ready", n), 64'(in_ready), 64'(v.exp_ready));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", n), 64'(out_valid), 64'(v.exp_valid));
        if (v.exp_valid) begin
            chk($sformatf("vec%0d out_ch", n), 64'(out_ch), 64'(v.exp_ch));
            chk($sformatf("vec%0d out_data", n), 64'(out_data), 64'(32'hDEAD_0000 | 32'(v.exp_ch)));
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
        for (int i = 0; i < 3; i++) d3_in[i*16 +: 16] = 16'hA000 | 16'(i);
        for (int i = 0; i < 4; i++) d4_in[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);
        in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        v3 = '0; m3 = 1'b0; s3 = '0; or3 = 1'b0;
        v4 = '0; m4 = 1'b0; s4 = '0; or4 = 1'b0;

        //         mode sel  valid  ordy  exp_rdy  exp_v ch
        vecs[0]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
        vecs[1]  = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5};
        vecs[2]  = '{1'b0, 3'd5, 8'hDF, 1'b1, 8'h00, 1'b0, 3'd5};
        vecs[3]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6};
        vecs[4]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7};
        vecs[5]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};
        vecs[6]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1};
        vecs[7]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[8]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 1'b1, 3'd6};
        vecs[9]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[10] = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 1'b1, 3'd6};
        vecs[11] = '{1'b1, 3'd0, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[12] = '{1'b1, 3'd0, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[13] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd2};
        vecs[14] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd2};
        vecs[15] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd2};
        vecs[16] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3};
        vecs[17] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd3};
        vecs[18] = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3};
        vecs[19] = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3};

        // Power-on reset
        rst = 1'b1;
        #1;
        chk("por out_valid", 64'(out_valid), 64'(0));
        chk("por out_data", 64'(out_data), 64'(0));
        chk("por out_ch", 64'(out_ch), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

        // Reset while the output register is full
        chk("pre-reset out_valid", 64'(out_valid), 64'(1));
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'(0));
        chk("midrst out_data", 64'(out_data), 64'(0));
        chk("midrst out_ch", 64'(out_ch), 64'(0));
        chk("midrst in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst held out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Round-robin sweep from reset: 0..7,0,1 with no bubbles
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("sweep%0d in_ready", k), 64'(in_ready), 64'(8'h01 << (k % 8)));
            @(posedge clk);
            #1;
            chk($sformatf("sweep%0d out_valid", k), 64'(out_valid), 64'(1));
            chk($sformatf("sweep%0d out_ch", k), 64'(out_ch), 64'(k % 8));
            chk($sformatf("sweep%0d out_data", k), 64'(out_data), 64'(32'hDEAD_0000 | 32'(k % 8)));
            @(negedge clk);
        end
        in_valid = '0;

        // Small configurations: RR wrap on 3 and 4 channels
        m3 = 1'b1; v3 = 3'b111; or3 = 1'b1;
        m4 = 1'b1; v4 = 4'hF; or4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n3 rr%0d out_ch", k), 64'(ch3), 64'(k % 3));
            chk($sformatf("n3 rr%0d out_data", k), 64'(od3), 64'(16'hA000 | 16'(k % 3)));
            chk($sformatf("n4 rr%0d out_ch", k), 64'(ch4), 64'(k % 4));
            chk($sformatf("n4 rr%0d out_data", k), 64'(od4), 64'(64'hC0DE_0000_0000_0000 | 64'(k % 4)));
            @(negedge clk);
        end

        // Out-of-range fixed select on 3 channels grants nothing
        m3 = 1'b0; s3 = 2'd3;
        #1;
        chk("n3 sel3 in_ready", 64'(r3), 64'(0));
        @(posedge clk);
        #1;
        chk("n3 sel3 out_valid", 64'(ov3), 64'(0));
        @(negedge clk);
        s3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 64'(r3), 64'(3'b100));
        @(posedge clk);
        #1;
        chk("n3 sel2 out_ch", 64'(ch3), 64'(2));
        chk("n3 sel2 out_data", 64'(od3), 64'(16'hA002));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
